muldiv_seq: RTL

- Multi-cycle sequencer in front of the combinational M-extension unit `alu_muldiv`.
- Accepts one mul/div request at a time from the execute stage over a valid/ready handshake and registers the operands and opcode.
- Holds those registers stable for a fixed number of cycles per operation class, so the datapath can be timed as a multicycle path.
- Captures the result and division-by-zero flag, then presents them on a valid/ready response port. Supports pipeline flush.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/alu_muldiv.sv | 78 +++++++
 rtl/muldiv_seq_top.sv | 72 +++++++
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the mul/div sequencer and the M-extension datapath.
//   - ALU opcode encodings MUL..REMU (01001..10000), common to both sides
//   - sequencer state encoding
//   - is_div_op(): true for the divide/remainder class (01101..10000)
package muldiv_seq_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_MUL    = 5'b01001;
  localparam logic [OPC_W-1:0] OP_MULH   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MULHSU = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MULHU  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_DIV    = 5'b01101;
  localparam logic [OPC_W-1:0] OP_DIVU   = 5'b01110;
  localparam logic [OPC_W-1:0] OP_REM    = 5'b01111;
  localparam logic [OPC_W-1:0] OP_REMU   = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [OPC_W-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Combinational RISC-V M-extension datapath.
// Ports:
//   opcode    in  5  operation select (MUL..REMU), anything else yields 0
//   rega      in  N  operand A
//   regb      in  N  operand B
//   res       out N  result
//   divbyzero out 1  div-class opcode with regb == 0
// Results follow the RISC-V rules: x/0 = all ones, x%0 = x,
// MIN/-1 = MIN, MIN%-1 = 0. Intended to be timed as a multicycle path
// behind muldiv_seq, whose operand registers stay frozen while it settles.
module alu_muldiv
  import muldiv_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [N-1:0]     rega,
  input  logic [N-1:0]     regb,
  output logic [N-1:0]     res,
  output logic             divbyzero
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic              a_signed;
  logic              b_signed;
  logic [2*N-1:0]    a_ext;
  logic [2*N-1:0]    b_ext;
  logic [2*N-1:0]    prod;
  logic              b_zero;
  logic              div_ovf;
  logic [N-1:0]      safe_bs;
  logic [N-1:0]      safe_bu;
  logic signed [N-1:0] quot_s;
  logic signed [N-1:0] rem_s;
  logic [N-1:0]      quot_u;
  logic [N-1:0]      rem_u;

  always_comb begin
    // One shared 2N-bit multiplier; the operand extension picks the
    // signedness. The low half is identical for every extension, so MUL
    // simply takes prod[N-1:0].
    a_signed = (opcode != OP_MULHU);
    b_signed = (opcode == OP_MUL) || (opcode == OP_MULH);
    a_ext    = {{N{a_signed & rega[N-1]}}, rega};
    b_ext    = {{N{b_signed & regb[N-1]}}, regb};
    prod     = a_ext * b_ext;

    // Divisors are replaced by 1 in the special cases so the dividers
    // never see /0 or overflow; with divisor 1 the signed overflow case
    // naturally gives quotient MIN and remainder 0.
    b_zero  = (regb == '0);
    div_ovf = (rega == MIN_NEG) && (regb == '1);
    safe_bs = (b_zero || div_ovf) ? ONE : regb;
    safe_bu = b_zero ? ONE : regb;
    quot_s  = $signed(rega) / $signed(safe_bs);
    rem_s   = $signed(rega) % $signed(safe_bs);
    quot_u  = rega / safe_bu;
    rem_u   = rega % safe_bu;

    res = '0;
    case (opcode)
      OP_MUL:    res = prod[N-1:0];
      OP_MULH:   res = prod[2*N-1:N];
      OP_MULHSU: res = prod[2*N-1:N];
      OP_MULHU:  res = prod[2*N-1:N];
      OP_DIV:    res = b_zero ? '1   : $unsigned(quot_s);
      OP_DIVU:   res = b_zero ? '1   : quot_u;
      OP_REM:    res = b_zero ? rega : $unsigned(rem_s);
      OP_REMU:   res = b_zero ? rega : rem_u;
      default:   res = '0;
    endcase

    divbyzero = is_div_op(opcode) && b_zero;
  end

endmodule

// File: rtl/muldiv_seq_top.sv
// Wrapper tying the sequencer's frozen operand registers to the
// combinational alu_muldiv datapath.
// Ports: clk, rst, flush, request handshake + payload, response
// handshake + payload, busy (same meaning as on muldiv_seq).
module muldiv_seq_top
  import muldiv_seq_pkg::*;
#(
  parameter int N          = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPC_W-1:0] req_opcode,
  input  logic [N-1:0]     req_rega,
  input  logic [N-1:0]     req_regb,
  input  logic [4:0]       req_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_data,
  output logic [4:0]       resp_rd,
  output logic             resp_divbyzero,
  output logic             busy
);

  logic [N-1:0]     md_rega;
  logic [N-1:0]     md_regb;
  logic [OPC_W-1:0] md_opcode;
  logic [N-1:0]     md_res;
  logic             md_divbyzero;

  muldiv_seq #(
    .N          (N),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_seq (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_rega       (req_rega),
    .req_regb       (req_regb),
    .req_rd         (req_rd),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_rd        (resp_rd),
    .resp_divbyzero (resp_divbyzero),
    .busy           (busy),
    .md_rega        (md_rega),
    .md_regb        (md_regb),
    .md_opcode      (md_opcode),
    .md_res         (md_res),
    .md_divbyzero   (md_divbyzero)
  );

  alu_muldiv #(
    .N (N)
  ) u_alu (
    .opcode    (md_opcode),
    .rega      (md_rega),
    .regb      (md_regb),
    .res       (md_res),
    .divbyzero (md_divbyzero)
  );

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer in front of the combinational alu_muldiv datapath.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop the in-flight operation
//   req_valid/req_ready       request handshake (req_ready is combinational)
//   req_opcode/rega/regb/rd   request payload; rd is echoed on resp_rd
//   resp_valid/resp_ready     response handshake
//   resp_data/rd/divbyzero    registered response payload
//   busy                      state != IDLE
//   md_rega/regb/opcode       frozen operands towards the datapath
//   md_res/md_divbyzero       combinational datapath result
// An accepted op spends L EXEC cycles (L = DIV_CYCLES for div-class,
// MUL_CYCLES otherwise, 1 for a div-class op with regb == 0) before the
// datapath output is captured into resp_*.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int N          = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPC_W-1:0] req_opcode,
  input  logic [N-1:0]     req_rega,
  input  logic [N-1:0]     req_regb,
  input  logic [4:0]       req_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_data,
  output logic [4:0]       resp_rd,
  output logic             resp_divbyzero,
  output logic             busy,
  output logic [N-1:0]     md_rega,
  output logic [N-1:0]     md_regb,
  output logic [OPC_W-1:0] md_opcode,
  input  logic [N-1:0]     md_res,
  input  logic             md_divbyzero
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_load;
  logic [4:0]       rd_reg;
  logic             accept;
  logic             capture;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    busy       = (state_reg != ST_IDLE);

    req_ready = !flush &&
                ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && resp_ready));
    accept    = req_valid && req_ready;
    capture   = (state_reg == ST_EXEC) && (cnt_reg == '0) && !flush;

    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: if (cnt_reg == '0) state_next = ST_DONE;
      ST_DONE: begin
        // A new op accepted while handing off the old result goes
        // straight back to EXEC.
        if (accept)          state_next = ST_EXEC;
        else if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (flush) state_next = ST_IDLE;
  end

  // Cycle budget for the incoming op; a zero divisor short-circuits to a
  // single EXEC cycle since the result does not need the divider.
  always_comb begin
    cnt_load = MUL_LOAD;
    if (is_div_op(req_opcode)) begin
      cnt_load = (req_regb == '0) ? '0 : DIV_LOAD;
    end
  end

  // Operand registers: loaded only on accept, so the datapath inputs
  // stay put for the whole EXEC window.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_rega   <= '0;
      md_regb   <= '0;
      md_opcode <= '0;
      rd_reg    <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      md_rega   <= req_rega;
      md_regb   <= req_regb;
      md_opcode <= req_opcode;
      rd_reg    <= req_rd;
      cnt_reg   <= cnt_load;
    end else if ((state_reg == ST_EXEC) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_rd        <= '0;
      resp_divbyzero <= 1'b0;
    end else begin
      if (capture) begin
        resp_data      <= md_res;
        resp_divbyzero <= md_divbyzero;
        resp_rd        <= rd_reg;
      end

      if (flush) begin
        resp_valid <= 1'b0;
      end else if (capture) begin
        resp_valid <= 1'b1;
      end else if ((state_reg == ST_DONE) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
